// File: rtl/i2s_rx_if.sv
// I2S receiver bus: serial inputs from the external transmitter plus the
// parallel stereo sample outputs presented to the PWM stage.
interface i2s_rx_if #(
    parameter int WIDTH = 24
);
    logic             bck;
    logic             lrck;
    logic             sdata;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] sample_r;
    logic             sample_valid;
    logic             short_err;

    modport master (
        output bck, lrck, sdata,
        input  sample, sample_r, sample_valid, short_err
    );

    modport slave (
        input  bck, lrck, sdata,
        output sample, sample_r, sample_valid, short_err
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S deserialiser: synchronises an externally clocked BCK/LRCK/SDATA stream
// into the mck domain and emits paired left/right words with a frame strobe.
module i2s_rx #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2,
    parameter bit OFFSET_BIN  = 1'b1
) (
    input  logic     mck,
    input  logic     rst,
    i2s_rx_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] OUT_FLIP = OFFSET_BIN ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

    logic [SYNC_STAGES-1:0] bck_sync_q,   bck_sync_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q,  lrck_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic                   bck_prev_q,   bck_prev_d;
    logic                   lrck_prev_q,  lrck_prev_d;
    logic                   primed_q,     primed_d;
    state_t                 state_q,      state_d;
    logic [CNT_W-1:0]       bit_cnt_q,    bit_cnt_d;
    logic                   chan_q,       chan_d;
    logic [WIDTH-1:0]       shift_q,      shift_d;
    logic [WIDTH-1:0]       left_hold_q,  left_hold_d;
    logic                   left_ok_q,    left_ok_d;
    logic [WIDTH-1:0]       sample_q,     sample_d;
    logic [WIDTH-1:0]       sample_r_q,   sample_r_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   short_err_q,  short_err_d;

    logic             bck_s;
    logic             lrck_s;
    logic             sdata_s;
    logic             rise;
    logic             lrck_change;
    logic [WIDTH-1:0] word;

    assign bck_s       = bck_sync_q[SYNC_STAGES-1];
    assign lrck_s      = lrck_sync_q[SYNC_STAGES-1];
    assign sdata_s     = sdata_sync_q[SYNC_STAGES-1];
    assign rise        = bck_s & ~bck_prev_q;
    assign lrck_change = lrck_s ^ lrck_prev_q;
    assign word        = {shift_q[WIDTH-2:0], sdata_s};

    always_comb begin
        bck_sync_d     = {bck_sync_q[SYNC_STAGES-2:0], bus.bck};
        lrck_sync_d    = {lrck_sync_q[SYNC_STAGES-2:0], bus.lrck};
        sdata_sync_d   = {sdata_sync_q[SYNC_STAGES-2:0], bus.sdata};
        bck_prev_d     = bck_s;
        lrck_prev_d    = lrck_prev_q;
        primed_d       = primed_q;
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        chan_d         = chan_q;
        shift_d        = shift_q;
        left_hold_d    = left_hold_q;
        left_ok_d      = left_ok_q;
        sample_d       = sample_q;
        sample_r_d     = sample_r_q;
        sample_valid_d = 1'b0;
        short_err_d    = short_err_q;

        if (rise) begin
            lrck_prev_d = lrck_s;
            case (state_q)
                IDLE: begin
                    // The first rise after reset only establishes the lrck reference.
                    if (!primed_q) begin
                        primed_d = 1'b1;
                    end else if (lrck_change) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                        chan_d    = lrck_s;
                    end
                end
                SHIFT: begin
                    if (lrck_change) begin
                        short_err_d = 1'b1;
                        left_ok_d   = 1'b0;
                        bit_cnt_d   = '0;
                        chan_d      = lrck_s;
                    end else begin
                        shift_d   = word;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_d = PAD;
                            if (!chan_q) begin
                                left_hold_d = word;
                                left_ok_d   = 1'b1;
                            end else if (left_ok_q) begin
                                sample_d       = left_hold_q ^ OUT_FLIP;
                                sample_r_d     = word ^ OUT_FLIP;
                                sample_valid_d = 1'b1;
                                left_ok_d      = 1'b0;
                            end
                        end
                    end
                end
                PAD: begin
                    if (lrck_change) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                        chan_d    = lrck_s;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge mck or posedge rst) begin
        if (rst) begin
            bck_sync_q     <= '0;
            lrck_sync_q    <= '0;
            sdata_sync_q   <= '0;
            bck_prev_q     <= 1'b0;
            lrck_prev_q    <= 1'b0;
            primed_q       <= 1'b0;
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            chan_q         <= 1'b0;
            shift_q        <= '0;
            left_hold_q    <= '0;
            left_ok_q      <= 1'b0;
            sample_q       <= OUT_FLIP;
            sample_r_q     <= OUT_FLIP;
            sample_valid_q <= 1'b0;
            short_err_q    <= 1'b0;
        end else begin
            bck_sync_q     <= bck_sync_d;
            lrck_sync_q    <= lrck_sync_d;
            sdata_sync_q   <= sdata_sync_d;
            bck_prev_q     <= bck_prev_d;
            lrck_prev_q    <= lrck_prev_d;
            primed_q       <= primed_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            chan_q         <= chan_d;
            shift_q        <= shift_d;
            left_hold_q    <= left_hold_d;
            left_ok_q      <= left_ok_d;
            sample_q       <= sample_d;
            sample_r_q     <= sample_r_d;
            sample_valid_q <= sample_valid_d;
            short_err_q    <= short_err_d;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_r     = sample_r_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.short_err    = short_err_q;

endmodule
